// File: rtl/fifo_sync_fwft_lvl.sv
// rtl/fifo_sync_fwft_lvl.sv - FWFT synchronous FIFO with fill level, programmable flags, flush and error pulses
module fifo_sync_fwft_lvl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int PROG_FULL  = DEPTH / 2,
    parameter int PROG_EMPTY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       prog_full,
    output logic [WIDTH-1:0]           dout,
    input  logic                       rd_en,
    output logic                       empty,
    output logic                       prog_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int MEM_D = DEPTH - 1;
    localparam int PW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    if (WIDTH < 1 || DEPTH < 2 || PROG_FULL < 1 || PROG_FULL > DEPTH ||
        PROG_EMPTY < 0 || PROG_EMPTY > DEPTH - 1) begin : g_bad_params
        $error("fifo_sync_fwft_lvl: parameter out of range");
    end

    // The head word lives in dout; the ring buffer holds the remaining DEPTH-1 words.
    logic [WIDTH-1:0] mem [MEM_D];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    logic          wr_acc;
    logic          rd_acc;
    logic          mem_wr;
    logic          mem_rd;
    logic          head_load;
    logic [LW-1:0] level_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MEM_D - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_acc    = wr_en && !full;
        rd_acc    = rd_en && !empty;
        mem_rd    = rd_acc && (level > LW'(1));
        head_load = wr_acc && (empty || (rd_acc && level == LW'(1)));
        mem_wr    = wr_acc && !head_load;
        level_nxt = level;
        if (wr_acc && !rd_acc) begin
            level_nxt = level + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr && !rst && !flush) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            dout       <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            level      <= level_nxt;
            empty      <= (level_nxt == '0);
            full       <= (level_nxt == LW'(DEPTH));
            prog_full  <= (level_nxt >= LW'(PROG_FULL));
            prog_empty <= (level_nxt <= LW'(PROG_EMPTY));
            overflow   <= wr_en && full;
            underflow  <= rd_en && empty;
            if (mem_wr) begin
                wptr <= ptr_inc(wptr);
            end
            if (mem_rd) begin
                rptr <= ptr_inc(rptr);
                dout <= mem[rptr];
            end else if (head_load) begin
                dout <= din;
            end
        end
    end
endmodule

// File: tb/tb_fifo_sync_fwft_lvl.sv
// tb/tb_fifo_sync_fwft_lvl.sv - directed and scoreboard bench for fifo_sync_fwft_lvl
module tb_fifo_sync_fwft_lvl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       a_flush = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_full, a_pfull, a_empty, a_pempty, a_ovf, a_unf;
    logic [5:0] a_level;

    logic       b_flush = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_full, b_pfull, b_empty, b_pempty, b_ovf, b_unf;
    logic [2:0] b_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync_fwft_lvl #(.WIDTH(8), .DEPTH(32)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .din(a_din), .wr_en(a_wr),
        .full(a_full), .prog_full(a_pfull), .dout(a_dout), .rd_en(a_rd),
        .empty(a_empty), .prog_empty(a_pempty), .level(a_level),
        .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_sync_fwft_lvl #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .din(b_din), .wr_en(b_wr),
        .full(b_full), .prog_full(b_pfull), .dout(b_dout), .rd_en(b_rd),
        .empty(b_empty), .prog_empty(b_pempty), .level(b_level),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (a_level !== 6'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", a_level); end
        checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", a_empty, a_full); end
        checks++; if (a_pempty !== 1'b1 || a_pfull !== 1'b0) begin errors++; $display("FAIL reset_prog got %b%b exp 10", a_pempty, a_pfull); end
        checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", a_ovf, a_unf); end
        checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", a_dout); end
        checks++; if (b_level !== 3'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL reset_b got lvl %0d empty %b exp 0 1", b_level, b_empty); end
    endtask

    task automatic test_single();
        a_din = 8'hA5; a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        checks++; if (a_empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", a_empty); end
        checks++; if (a_dout !== 8'hA5) begin errors++; $display("FAIL single_dout got %h exp a5", a_dout); end
        checks++; if (a_level !== 6'd1) begin errors++; $display("FAIL single_level got %0d exp 1", a_level); end
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++; if (a_empty !== 1'b1 || a_level !== 6'd0) begin errors++; $display("FAIL single_pop got empty %b lvl %0d exp 1 0", a_empty, a_level); end
        checks++; if (a_dout !== 8'hA5) begin errors++; $display("FAIL single_hold got %h exp a5", a_dout); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            a_din = 8'(i); a_wr = 1'b1;
            tick();
            checks++; if (a_level !== 6'(i + 1)) begin errors++; $display("FAIL fill_level got %0d exp %0d", a_level, i + 1); end
            checks++; if (a_full !== (i + 1 == 32)) begin errors++; $display("FAIL fill_full at %0d got %b", i + 1, a_full); end
            checks++; if (a_pfull !== (i + 1 >= 16)) begin errors++; $display("FAIL fill_pfull at %0d got %b", i + 1, a_pfull); end
            checks++; if (a_pempty !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_pempty at %0d got %b", i + 1, a_pempty); end
        end
        a_din = 8'd99;
        tick();
        a_wr = 1'b0;
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", a_ovf); end
        checks++; if (a_level !== 6'd32) begin errors++; $display("FAIL ovf_level got %0d exp 32", a_level); end
        tick();
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_single got %b exp 0", a_ovf); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (a_dout !== 8'(i)) begin errors++; $display("FAIL drain_data got %0d exp %0d", a_dout, i); end
            a_rd = 1'b1;
            tick();
            checks++; if (a_level !== 6'(31 - i)) begin errors++; $display("FAIL drain_level got %0d exp %0d", a_level, 31 - i); end
            checks++; if (a_pempty !== (31 - i <= 2)) begin errors++; $display("FAIL drain_pempty at %0d got %b", 31 - i, a_pempty); end
            checks++; if (a_empty !== (i == 31)) begin errors++; $display("FAIL drain_empty at %0d got %b", 31 - i, a_empty); end
        end
        a_rd = 1'b0;
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 32; i++) begin
            a_din = 8'(100 + i); a_wr = 1'b1;
            tick();
        end
        checks++; if (a_full !== 1'b1 || a_dout !== 8'd100) begin errors++; $display("FAIL frw_pre got full %b dout %0d exp 1 100", a_full, a_dout); end
        a_din = 8'hEE; a_rd = 1'b1;
        tick();
        a_wr = 1'b0;
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL frw_ovf got %b exp 1", a_ovf); end
        checks++; if (a_level !== 6'd31) begin errors++; $display("FAIL frw_level got %0d exp 31", a_level); end
        for (int i = 1; i < 32; i++) begin
            checks++; if (a_dout !== 8'(100 + i)) begin errors++; $display("FAIL frw_data got %0d exp %0d", a_dout, 100 + i); end
            tick();
        end
        a_rd = 1'b0;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL frw_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            a_din = 8'(16 + i); a_wr = 1'b1;
            tick();
        end
        checks++; if (a_level !== 6'd7) begin errors++; $display("FAIL flush_pre got %0d exp 7", a_level); end
        a_flush = 1'b1; a_rd = 1'b1; a_din = 8'h55;
        tick();
        a_flush = 1'b0; a_wr = 1'b0;
        checks++; if (a_level !== 6'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL flush_state got lvl %0d empty %b exp 0 1", a_level, a_empty); end
        checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL flush_pulses got %b%b exp 00", a_ovf, a_unf); end
        checks++; if (a_pempty !== 1'b1 || a_pfull !== 1'b0) begin errors++; $display("FAIL flush_prog got %b%b exp 10", a_pempty, a_pfull); end
        checks++; if (a_dout !== 8'd16) begin errors++; $display("FAIL flush_dout got %0d exp 16", a_dout); end
        tick();
        a_rd = 1'b0;
        checks++; if (a_unf !== 1'b1) begin errors++; $display("FAIL unf_pulse got %b exp 1", a_unf); end
        tick();
        checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_single got %b exp 0", a_unf); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            a_din = 8'(64 + i); a_wr = 1'b1;
            tick();
        end
        checks++; if (a_level !== 6'd10) begin errors++; $display("FAIL rmid_pre got %0d exp 10", a_level); end
        a_din = 8'h99; a_rd = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
        checks++; if (a_level !== 6'd0 || a_empty !== 1'b1 || a_full !== 1'b0) begin errors++; $display("FAIL rmid_state got lvl %0d empty %b full %b", a_level, a_empty, a_full); end
        checks++; if (a_dout !== 8'h00 || a_pempty !== 1'b1 || a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL rmid_outs got dout %h pe %b ov %b un %b", a_dout, a_pempty, a_ovf, a_unf); end
        a_wr = 1'b1; a_din = 8'h77;
        tick();
        a_din = 8'h78;
        tick();
        a_wr = 1'b0;
        checks++; if (a_level !== 6'd2 || a_dout !== 8'h77) begin errors++; $display("FAIL rmid_new0 got lvl %0d dout %h exp 2 77", a_level, a_dout); end
        a_rd = 1'b1;
        tick();
        checks++; if (a_dout !== 8'h78) begin errors++; $display("FAIL rmid_new1 got %h exp 78", a_dout); end
        tick();
        a_rd = 1'b0;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL rmid_end got empty %b exp 1", a_empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic w, r, wacc, racc;
        while (got < 40 && cyc < 2000) begin
            checks++; if (b_level !== 3'(q.size())) begin errors++; $display("FAIL wrap_level got %0d exp %0d", b_level, q.size()); end
            if (q.size() > 0) begin
                checks++; if (b_dout !== q[0]) begin errors++; $display("FAIL wrap_data got %0d exp %0d", b_dout, q[0]); end
            end
            w = (sent < 40) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) == 1);
            wacc = w && (q.size() < 5);
            racc = r && (q.size() > 0);
            b_wr = w; b_rd = r; b_din = 8'(sent);
            tick();
            checks++; if (b_ovf !== (w && q.size() == 5)) begin errors++; $display("FAIL wrap_ovf got %b", b_ovf); end
            if (racc) begin void'(q.pop_front()); got++; end
            if (wacc) begin q.push_back(8'(sent)); sent++; end
            cyc++;
        end
        b_wr = 1'b0; b_rd = 1'b0;
        checks++; if (got != 40) begin errors++; $display("FAIL wrap_timeout got %0d words exp 40", got); end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_fill_drain();
        test_full_rw();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
